// File: rtl/pw_uart_sender.sv
// pw_uart_sender
//   Transmit side of the password link. A Start request sent while the block is
//   idle causes it to send a fixed 4-byte password as back-to-back UART 8N1
//   frames on Tx_out. Each bit is sent LSB first and is held for CLKS_PER_BIT
//   Clkin cycles.
// Ports
//   Clkin   : system clock. All logic runs on its rising edge.
//   Rst     : synchronous, active-high reset. It aborts any frame in progress.
//   Start   : send request. It is only sampled while idle.
//   Tx_out  : registered serial line. The idle (mark) level is 1.
//   Busy    : registered. High from the first start-bit cycle through the last
//             stop-bit cycle.
//   Done    : registered. Pulses for one cycle after the last stop bit of byte 3.
module pw_uart_sender #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter logic [7:0]  PW_B0        = 8'h61,
  parameter logic [7:0]  PW_B1        = 8'h62,
  parameter logic [7:0]  PW_B2        = 8'h63,
  parameter logic [7:0]  PW_B3        = 8'h64
) (
  input  logic Clkin,
  input  logic Rst,
  input  logic Start,
  output logic Tx_out,
  output logic Busy,
  output logic Done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic          tx_n, busy_n, done_n;
  logic [7:0]    cur_byte;

  always_ff @(posedge Clkin) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      Tx_out   <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      Tx_out   <= tx_n;
      Busy     <= busy_n;
      Done     <= done_n;
    end
  end

  // The outputs are registered, so they are decoded from the next-state values.
  // This makes Tx_out, Busy and Done line up with the state that is entered on
  // the same edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (Start) begin
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      START: begin
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (byte_idx == 2'd3) begin
            state_n = IDLE;
            byte_n  = '0;
            done_n  = 1'b1;
          end else begin
            byte_n  = byte_idx + 2'd1;
            state_n = START;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (byte_n)
      2'd0:    cur_byte = PW_B0;
      2'd1:    cur_byte = PW_B1;
      2'd2:    cur_byte = PW_B2;
      default: cur_byte = PW_B3;
    endcase

    busy_n = (state_n != IDLE);
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pw_uart_sender.sv
// tb_pw_uart_sender
//   Testbench for pw_uart_sender with CLKS_PER_BIT=4. A bench-side model works
//   out the expected Tx_out, Busy and Done for every cycle from the position
//   inside the 160-cycle password waveform. A bench UART receiver decodes the
//   line and checks the bytes it recovers.
module tb_pw_uart_sender;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic tx, busy, done;

  pw_uart_sender #(
    .CLKS_PER_BIT(CPB),
    .PW_B0(8'h61), .PW_B1(8'h62), .PW_B2(8'h63), .PW_B3(8'h64)
  ) dut (
    .Clkin(clk), .Rst(rst), .Start(start),
    .Tx_out(tx), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] pw [4] = '{8'h61, 8'h62, 8'h63, 8'h64};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // rel = 0 while idle. Otherwise it is the 1-based cycle position in the
  // password waveform: 1..160 are bit cycles and 161 is the Done cycle.
  function automatic void model_out(input int r, output logic etx, output logic ebusy, output logic edone);
    int k, b, p;
    logic [7:0] byte_v;
    etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    if (r >= 1 && r <= 40*CPB) begin
      k = r - 1;
      b = k / (10*CPB);
      p = (k % (10*CPB)) / CPB;
      byte_v = pw[b];
      ebusy = 1'b1;
      if (p == 0)      etx = 1'b0;
      else if (p == 9) etx = 1'b1;
      else             etx = byte_v[p-1];
    end else if (r == 40*CPB + 1) begin
      edone = 1'b1;
    end
  endfunction

  int   edge_n = 0;
  int   rel = 0;
  bit   armed = 0;
  logic prev_busy = 1'b0;
  int   done_q[$];
  int   rise_q[$];

  always @(posedge clk) begin
    logic etx, ebusy, edone;
    edge_n++;
    if (rst) rel = 0;
    else if ((rel == 0 || rel == 40*CPB + 1) && start) rel = 1;
    else if (rel >= 1 && rel <= 40*CPB) rel++;
    else rel = 0;
    if (rst) armed = 1;
    #1;
    if (armed) begin
      model_out(rel, etx, ebusy, edone);
      check("tx", {31'd0, tx}, {31'd0, etx});
      check("busy", {31'd0, busy}, {31'd0, ebusy});
      check("done", {31'd0, done}, {31'd0, edone});
      if (done === 1'b1) done_q.push_back(edge_n);
      if (busy === 1'b1 && prev_busy !== 1'b1) rise_q.push_back(edge_n);
      prev_busy = busy;
    end
  end

  // Loopback receiver. It samples the middle of each bit, counted from the
  // first low cycle of the start bit.
  bit         rx_busy = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];
  int         ferr = 0;

  always @(posedge clk) begin
    int k;
    #2;
    if (rst) begin
      rx_busy = 0;
    end else if (armed) begin
      if (!rx_busy) begin
        if (tx === 1'b0) begin
          rx_busy = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_busy && (rx_cnt % CPB) == CPB/2) begin
        k = rx_cnt / CPB;
        if (k == 0) begin
          if (tx !== 1'b0) begin
            ferr++;
            rx_busy = 0;
          end
        end else if (k <= 8) begin
          rx_sh[k-1] = tx;
        end else begin
          if (tx !== 1'b1) ferr++;
          rx_q.push_back(rx_sh);
          rx_busy = 0;
        end
      end
    end
  end

  task automatic clear_obs();
    done_q.delete();
    rise_q.delete();
    rx_q.delete();
    ferr = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_rx(input string name, input int nbytes);
    check({name, "_rx_count"}, rx_q.size(), nbytes);
    for (int i = 0; i < nbytes && i < rx_q.size(); i++)
      check({name, "_rx_byte"}, {24'd0, rx_q[i]}, {24'd0, pw[i % 4]});
    check({name, "_framing"}, ferr, 0);
  endtask

  task automatic check_timing(input string name, input int idx, input int exp_cycle);
    if (done_q.size() > idx && rise_q.size() > 0)
      check(name, done_q[idx] - rise_q[0] + 1, exp_cycle);
    else
      check({name, "_missing"}, done_q.size(), idx + 1);
  endtask

  initial begin
    // 1: reset, then stay idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (50) @(negedge clk);
    check("idle_done_count", done_q.size(), 0);
    check("idle_busy_rises", rise_q.size(), 0);

    // 2: a single password
    clear_obs();
    pulse_start();
    repeat (170) @(negedge clk);
    check("s2_done_count", done_q.size(), 1);
    check_timing("s2_done_after_first0", 0, 161);
    check_rx("s2", 4);

    // 3: extra Start pulses while busy must be ignored
    clear_obs();
    pulse_start();
    repeat (18) @(negedge clk);
    pulse_start();
    repeat (79) @(negedge clk);
    pulse_start();
    repeat (80) @(negedge clk);
    check("s3_done_count", done_q.size(), 1);
    check("s3_busy_rises", rise_q.size(), 1);
    check_timing("s3_done_after_first0", 0, 161);
    check_rx("s3", 4);

    // 4: reset during byte 2, data bit 3, then a fresh send
    clear_obs();
    pulse_start();
    repeat (97) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s4_busy_after_rst", {31'd0, busy}, 32'd0);
    check("s4_tx_after_rst", {31'd0, tx}, 32'd1);
    repeat (80) @(negedge clk);
    check("s4_no_done", done_q.size(), 0);
    clear_obs();
    pulse_start();
    repeat (170) @(negedge clk);
    check("s4_done_count", done_q.size(), 1);
    check_rx("s4", 4);

    // 5: Start held high gives back-to-back passwords
    clear_obs();
    start = 1'b1;
    repeat (400) @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("s5_done_count", done_q.size(), 3);
    check_timing("s5_done1_cycle", 0, 161);
    check_timing("s5_done2_cycle", 1, 322);
    check_rx("s5", 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
